// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared register-bank geometry for the regfile and its write arbiter
package proc_pkg;
    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;
    localparam int IDW      = 3;

    typedef logic [IDW-1:0] req_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-wide round-robin arbiter with externally qualified pointer update
module rr_arbiter
    import proc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [N-1:0]  i_valid,
    input  logic          i_update,
    output logic [N-1:0]  o_grant,
    output req_idx_t      o_idx
);
    req_idx_t r_ptr;
    int       w_dist;
    int       w_best;

    // Lowest rotational distance past the pointer wins; the pointer itself is last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_best  = N;
        w_dist  = 0;
        if (i_en) begin
            for (int i = 0; i < N; i++) begin
                w_dist = (i - int'(r_ptr) - 1 + 2 * N) % N;
                if (i_valid[i] && (w_dist < w_best)) begin
                    w_best = w_dist;
                    o_idx  = req_idx_t'(i);
                end
            end
            if (w_best < N) begin
                o_grant[o_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= o_idx;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the register bank write port
module regfile_write_arbiter
    import proc_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_hold,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    input  logic [NREQ*DW-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREG-1:0]      o_we_out,
    output logic [DW-1:0]        o_din_out,
    output logic [IDW-1:0]       o_grant_id,
    output logic                 o_addr_err,
    output logic [15:0]          o_stall_cnt
);
    logic [NREQ-1:0] w_grant;
    req_idx_t        w_idx;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_addr_bad;
    logic            w_addr_zero;
    logic            w_stall;
    logic [NREG-1:0] w_we;

    logic [NREG-1:0] r_we;
    logic [DW-1:0]   r_din;
    logic [IDW-1:0]  r_gid;
    logic            r_err;
    logic [15:0]     r_stall;

    // Ready is held low during reset as well as during a pipeline hold.
    rr_arbiter #(.N(NREQ)) u_rr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (!i_hold && i_rst_n),
        .i_valid  (i_req_valid),
        .i_update (w_xfer),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    assign o_req_ready = w_grant;
    assign w_xfer      = |(i_req_valid & w_grant);
    assign w_addr      = i_req_addr[int'(w_idx)*AW +: AW];
    assign w_data      = i_req_data[int'(w_idx)*DW +: DW];
    assign w_addr_bad  = int'(w_addr) >= NREG;
    assign w_addr_zero = int'(w_addr) == REG_ZERO;
    assign w_stall     = |(i_req_valid & ~w_grant);
    assign w_we        = (w_xfer && !w_addr_bad && !w_addr_zero) ? (NREG'(1) << w_addr) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= '0;
            r_din   <= '0;
            r_gid   <= '0;
            r_err   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_we <= w_we;
            if (w_xfer) begin
                r_din <= w_data;
                r_gid <= w_idx;
            end
            if (w_xfer && w_addr_bad) begin
                r_err <= 1'b1;
            end
            if (w_stall && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign o_we_out    = r_we;
    assign o_din_out   = r_din;
    assign o_grant_id  = r_gid;
    assign o_addr_err  = r_err;
    assign o_stall_cnt = r_stall;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int NREG = 16;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 hold;
    logic [NREQ-1:0]      valid;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   data;
    logic [NREQ-1:0]      ready;
    logic [NREG-1:0]      we;
    logic [DW-1:0]        din;
    logic [2:0]           gid;
    logic                 err;
    logic [15:0]          stall;

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .NREG(NREG), .AW(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hold      (hold),
        .i_req_valid (valid),
        .i_req_addr  (addr),
        .i_req_data  (data),
        .o_req_ready (ready),
        .o_we_out    (we),
        .o_din_out   (din),
        .o_grant_id  (gid),
        .o_addr_err  (err),
        .o_stall_cnt (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_chk = 0;
    int              n_err = 0;
    int              m_ptr, m_gid, m_stall;
    logic [NREG-1:0] m_we;
    logic [DW-1:0]   m_din;
    logic            m_err;
    int              last_g;
    logic [NREQ-1:0] last_rdy;
    bit              pend [NREQ];
    int              base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gid = 0; m_stall = 0; m_we = '0; m_din = '0; m_err = 1'b0;
    endtask

    function automatic int exp_grant();
        int c;
        if (hold || !rst_n) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (valid[c]) return c;
        end
        return -1;
    endfunction

    // Inputs are stable from just after one edge to the next; checks land mid-cycle.
    task automatic tick();
        int              g;
        int              a;
        logic [NREQ-1:0] er;
        #3;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", 32'(ready), 32'(er));
        last_rdy = ready;
        @(posedge clk);
        if (((valid & ~er) != '0) && (m_stall < 65535)) m_stall++;
        if (g >= 0) begin
            m_ptr = g;
            m_gid = g;
            m_din = data[g*DW +: DW];
            a     = int'(addr[g*AW +: AW]);
            if (a >= NREG) m_err = 1'b1;
            m_we  = (a != 0 && a < NREG) ? (NREG'(1) << a) : '0;
        end else begin
            m_we = '0;
        end
        last_g = g;
        #1;
        chk("we", 32'(we), 32'(m_we));
        chk("din", din, m_din);
        chk("gid", 32'(gid), 32'(m_gid));
        chk("err", 32'(err), 32'(m_err));
        chk("stall", 32'(stall), 32'(m_stall));
    endtask

    task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
        addr[i*AW +: AW] = AW'(a);
        data[i*DW +: DW] = d;
    endtask

    initial begin
        int seq [6] = '{1, 2, 0, 1, 2, 0};
        rst_n = 1'b0; hold = 1'b0; valid = '1; addr = '0; data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_gid", 32'(gid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single source
        valid = 3'b001; set_req(0, 5, 32'hFFFF_FFFF);
        tick();
        chk("t1_rdy", 32'(last_rdy), 32'd1);
        chk("t1_we", 32'(we), 32'h20);
        chk("t1_din", din, 32'hFFFF_FFFF);
        valid = '0;
        tick();
        chk("t1_we0", 32'(we), 32'd0);

        // all three continuously valid
        valid = 3'b111;
        set_req(0, 1, 32'hA0); set_req(1, 2, 32'hA1); set_req(2, 3, 32'hA2);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_gid", 32'(gid), 32'(seq[i]));
        end

        // hold with two requesters
        valid = 3'b011; hold = 1'b1;
        base = int'(stall);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_we", 32'(we), 32'd0);
        end
        chk("t3_stall", 32'(stall), 32'(base + 4));
        hold = 1'b0;
        tick();
        chk("t3_gid1", 32'(gid), 32'd1);
        tick();
        chk("t3_gid0", 32'(gid), 32'd0);

        // address 0 and out-of-range address
        valid = 3'b001; set_req(0, 0, 32'h1234);
        tick();
        chk("t4_we_r0", 32'(we), 32'd0);
        chk("t4_din", din, 32'h1234);
        set_req(0, 20, 32'h5555);
        tick();
        chk("t4_we_bad", 32'(we), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        valid = '0;
        tick();
        chk("t4_err_sticky", 32'(err), 32'd1);

        // randomized traffic under the valid/ready protocol
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && last_g == i) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    set_req(i, int'($urandom_range(0, 31)), $urandom);
                end
                valid[i] = pend[i];
            end
            hold = ($urandom_range(0, 7) == 0);
            tick();
        end

        // asynchronous reset while a write is in the output stage
        hold = 1'b0; valid = 3'b001; set_req(0, 7, 32'hBEEF);
        tick();
        chk("t5_we_pre", 32'(we), 32'h80);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_din", din, 32'd0);
        chk("t5_stall", 32'(stall), 32'd0);
        chk("t5_ready", 32'(ready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 3'b111;
        set_req(0, 1, 32'hC0); set_req(1, 2, 32'hC1); set_req(2, 3, 32'hC2);
        tick();
        chk("t5_first", 32'(gid), 32'd1);

        // saturation of the stall counter
        hold = 1'b1; valid = 3'b100;
        repeat (70000) @(posedge clk);
        m_stall = 65535;
        #1;
        chk("t6_sat", 32'(stall), 32'hFFFF);
        tick();
        chk("t6_nowrap", 32'(stall), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
